// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch bus: memory req/ack handshake plus the delivered-fetch
// outputs toward IF/ID. The master side is the fetch unit.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            if_req_o;
    logic [XLEN-1:0] if_addr_o;
    logic            if_ack_i;
    logic            fetch_valid_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic [XLEN-1:0] fetch_pc_4_o;

    modport master (
        output if_req_o,
        output if_addr_o,
        input  if_ack_i,
        output fetch_valid_o,
        output fetch_pc_o,
        output fetch_pc_4_o
    );

    modport slave (
        input  if_req_o,
        input  if_addr_o,
        output if_ack_i,
        input  fetch_valid_o,
        input  fetch_pc_o,
        input  fetch_pc_4_o
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request generator. Holds one request to
// instruction memory at a time, applies exc > eret > branch redirects and
// squashes the in-flight fetch when a redirect makes it stale.
//
// state | meaning
// IDLE  | no request outstanding; redirects load pc_q directly
// REQ   | request for pc_q outstanding; redirects are parked in pend until ack
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [XLEN-1:0] EXC_VEC  = 32'hBFC0_0380,
    parameter int              INC      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redir_valid_i,
    input  logic [XLEN-1:0] redir_target_i,
    input  logic            exc_req_i,
    input  logic            eret_req_i,
    input  logic [XLEN-1:0] epc_i,
    pc_fetch_unit_if.master bus
);
    localparam logic [0:0]      IDLE  = 1'b0;
    localparam logic [0:0]      REQ   = 1'b1;
    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

    logic [0:0]      state;
    logic [XLEN-1:0] pc_q;
    logic            pend_valid;
    logic [1:0]      pend_rank;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] fetch_pc_q;
    logic            fetch_valid_q;

    logic            ev_valid;
    logic [1:0]      ev_rank;
    logic [XLEN-1:0] ev_target;
    logic            ev_wins;

    // Pick this cycle's redirect by priority; rank 0 means no event.
    always_comb begin
        ev_valid  = 1'b0;
        ev_rank   = 2'd0;
        ev_target = pc_q;
        if (exc_req_i) begin
            ev_valid  = 1'b1;
            ev_rank   = 2'd3;
            ev_target = EXC_VEC;
        end else if (eret_req_i) begin
            ev_valid  = 1'b1;
            ev_rank   = 2'd2;
            ev_target = epc_i;
        end else if (redir_valid_i) begin
            ev_valid  = 1'b1;
            ev_rank   = 2'd1;
            ev_target = redir_target_i;
        end
        // A newer event of equal rank replaces the parked one.
        ev_wins = ev_valid && (!pend_valid || (ev_rank >= pend_rank));
    end

    // PC, request state, parked redirect and delivered-fetch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= RESET_PC;
            pend_valid    <= 1'b0;
            pend_rank     <= 2'd0;
            pend_target   <= '0;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        pc_q <= ev_target;
                    end
                    if (!stall_i) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.if_ack_i) begin
                        if (!pend_valid && !ev_valid) begin
                            fetch_valid_q <= 1'b1;
                            fetch_pc_q    <= pc_q;
                            pc_q          <= pc_q + INC_W;
                        end else begin
                            pc_q <= ev_wins ? ev_target : pend_target;
                        end
                        pend_valid <= 1'b0;
                        if (stall_i) begin
                            state <= IDLE;
                        end
                    end else if (ev_wins) begin
                        pend_valid  <= 1'b1;
                        pend_rank   <= ev_rank;
                        pend_target <= ev_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address stays pc_q for the whole request since pc_q only moves on ack.
    always_comb begin
        bus.if_req_o      = (state == REQ);
        bus.if_addr_o     = pc_q;
        bus.fetch_valid_o = fetch_valid_q;
        bus.fetch_pc_o    = fetch_pc_q;
        bus.fetch_pc_4_o  = fetch_pc_q + INC_W;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir_v;
    logic [31:0] redir_t;
    logic        exc;
    logic        eret;
    logic [31:0] epc;

    int n_checks;
    int n_pass;

    pc_fetch_unit_if #(.XLEN(32)) bus ();

    pc_fetch_unit #(
        .XLEN(32), .RESET_PC(RST_PC), .EXC_VEC(EXC_PC), .INC(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall_i(stall),
        .redir_valid_i(redir_v),
        .redir_target_i(redir_t),
        .exc_req_i(exc),
        .eret_req_i(eret),
        .epc_i(epc),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        stall = 0; redir_v = 0; redir_t = '0; exc = 0; eret = 0; epc = '0;
        bus.if_ack_i = 0;
    endtask

    // Leaves rst_n released 1ns after a rising edge; the next edge is cycle 1.
    task automatic do_reset;
        quiet();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        do_reset();
        rst_n = 0;
        tick();
        n_checks++; if (bus.if_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", bus.if_req_o); else n_pass++;
        n_checks++; if (bus.if_addr_o !== RST_PC) $display("FAIL reset_addr got %h want %h", bus.if_addr_o, RST_PC); else n_pass++;
        n_checks++; if (bus.fetch_valid_o !== 1'b0) $display("FAIL reset_fv got %b want 0", bus.fetch_valid_o); else n_pass++;
        n_checks++; if (bus.fetch_pc_o !== RST_PC) $display("FAIL reset_fpc got %h want %h", bus.fetch_pc_o, RST_PC); else n_pass++;
        n_checks++; if (bus.fetch_pc_4_o !== 32'hBFC0_0004) $display("FAIL reset_fpc4 got %h want bfc00004", bus.fetch_pc_4_o); else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_free_run;
        logic [31:0] want;
        do_reset();
        bus.if_ack_i = 1;
        tick();
        n_checks++; if (bus.if_req_o !== 1'b1 || bus.if_addr_o !== RST_PC || bus.fetch_valid_o !== 1'b0)
            $display("FAIL free_first got req=%b addr=%h fv=%b want 1 %h 0", bus.if_req_o, bus.if_addr_o, bus.fetch_valid_o, RST_PC); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            want = RST_PC + 32'(4 * k);
            n_checks++; if (bus.if_addr_o !== want) $display("FAIL free_addr%0d got %h want %h", k, bus.if_addr_o, want); else n_pass++;
            n_checks++; if (bus.fetch_valid_o !== 1'b1 || bus.fetch_pc_o !== want - 32'd4 || bus.fetch_pc_4_o !== want)
                $display("FAIL free_fetch%0d got fv=%b pc=%h pc4=%h want 1 %h %h", k, bus.fetch_valid_o, bus.fetch_pc_o, bus.fetch_pc_4_o, want - 32'd4, want); else n_pass++;
        end
    endtask

    task automatic test_delayed_ack;
        int pulses;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.if_req_o !== 1'b1 || bus.if_addr_o !== RST_PC) $display("FAIL delay_hold%0d got req=%b addr=%h want 1 %h", k, bus.if_req_o, bus.if_addr_o, RST_PC); else n_pass++;
            if (k < 3) tick();
        end
        pulses = 0;
        bus.if_ack_i = 1;
        tick();
        bus.if_ack_i = 0;
        if (bus.fetch_valid_o === 1'b1) pulses++;
        n_checks++; if (bus.fetch_pc_o !== RST_PC || bus.if_addr_o !== 32'hBFC0_0004) $display("FAIL delay_fetch got pc=%h addr=%h want %h bfc00004", bus.fetch_pc_o, bus.if_addr_o, RST_PC); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.fetch_valid_o === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1) $display("FAIL delay_pulses got %0d want 1", pulses); else n_pass++;
    endtask

    task automatic test_redirect_squash;
        do_reset();
        tick();
        redir_v = 1; redir_t = 32'h0040_0100;
        tick();
        redir_v = 0;
        n_checks++; if (bus.if_addr_o !== RST_PC) $display("FAIL squash_hold got %h want %h", bus.if_addr_o, RST_PC); else n_pass++;
        tick();
        bus.if_ack_i = 1;
        tick();
        n_checks++; if (bus.fetch_valid_o !== 1'b0) $display("FAIL squash_fv got %b want 0", bus.fetch_valid_o); else n_pass++;
        n_checks++; if (bus.if_addr_o !== 32'h0040_0100 || bus.if_req_o !== 1'b1) $display("FAIL squash_addr got %h req=%b want 00400100 1", bus.if_addr_o, bus.if_req_o); else n_pass++;
        tick();
        n_checks++; if (bus.fetch_valid_o !== 1'b1 || bus.fetch_pc_o !== 32'h0040_0100) $display("FAIL squash_next got fv=%b pc=%h want 1 00400100", bus.fetch_valid_o, bus.fetch_pc_o); else n_pass++;
    endtask

    task automatic test_priority;
        do_reset();
        tick();
        bus.if_ack_i = 1;
        exc = 1; eret = 1; epc = 32'h0040_0020; redir_v = 1; redir_t = 32'h0040_0100;
        tick();
        exc = 0; redir_v = 0;
        n_checks++; if (bus.if_addr_o !== EXC_PC || bus.fetch_valid_o !== 1'b0) $display("FAIL prio_all got addr=%h fv=%b want %h 0", bus.if_addr_o, bus.fetch_valid_o, EXC_PC); else n_pass++;
        tick();
        eret = 0;
        n_checks++; if (bus.if_addr_o !== 32'h0040_0020) $display("FAIL prio_eret got %h want 00400020", bus.if_addr_o); else n_pass++;
        // Parked exception must survive a later, lower-priority branch.
        bus.if_ack_i = 0;
        exc = 1;
        tick();
        exc = 0; redir_v = 1; redir_t = 32'h1234_5678;
        tick();
        redir_v = 0; bus.if_ack_i = 1;
        tick();
        n_checks++; if (bus.if_addr_o !== EXC_PC || bus.fetch_valid_o !== 1'b0) $display("FAIL prio_pend got addr=%h fv=%b want %h 0", bus.if_addr_o, bus.fetch_valid_o, EXC_PC); else n_pass++;
    endtask

    task automatic test_stall;
        do_reset();
        tick();
        stall = 1; bus.if_ack_i = 1;
        tick();
        bus.if_ack_i = 0;
        n_checks++; if (bus.if_req_o !== 1'b0 || bus.fetch_valid_o !== 1'b1 || bus.fetch_pc_o !== RST_PC)
            $display("FAIL stall_ack got req=%b fv=%b pc=%h want 0 1 %h", bus.if_req_o, bus.fetch_valid_o, bus.fetch_pc_o, RST_PC); else n_pass++;
        redir_v = 1; redir_t = 32'h0040_0200;
        tick();
        redir_v = 0;
        tick();
        n_checks++; if (bus.if_req_o !== 1'b0) $display("FAIL stall_hold got req=%b want 0", bus.if_req_o); else n_pass++;
        stall = 0;
        tick();
        n_checks++; if (bus.if_req_o !== 1'b1 || bus.if_addr_o !== 32'h0040_0200) $display("FAIL stall_resume got req=%b addr=%h want 1 00400200", bus.if_req_o, bus.if_addr_o); else n_pass++;
        bus.if_ack_i = 1;
        tick();
        n_checks++; if (bus.fetch_valid_o !== 1'b1 || bus.fetch_pc_o !== 32'h0040_0200) $display("FAIL stall_nosquash got fv=%b pc=%h want 1 00400200", bus.fetch_valid_o, bus.fetch_pc_o); else n_pass++;
    endtask

    task automatic test_wrap_and_async_reset;
        do_reset();
        tick();
        bus.if_ack_i = 1; redir_v = 1; redir_t = 32'hFFFF_FFFC;
        tick();
        redir_v = 0;
        n_checks++; if (bus.if_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_load got %h want fffffffc", bus.if_addr_o); else n_pass++;
        tick();
        n_checks++; if (bus.if_addr_o !== 32'h0 || bus.fetch_pc_o !== 32'hFFFF_FFFC || bus.fetch_pc_4_o !== 32'h0)
            $display("FAIL wrap_next got addr=%h pc=%h pc4=%h want 0 fffffffc 0", bus.if_addr_o, bus.fetch_pc_o, bus.fetch_pc_4_o); else n_pass++;
        bus.if_ack_i = 0;
        tick();
        #2 rst_n = 0;
        #1;
        n_checks++; if (bus.if_req_o !== 1'b0 || bus.if_addr_o !== RST_PC || bus.fetch_valid_o !== 1'b0)
            $display("FAIL async_rst got req=%b addr=%h fv=%b want 0 %h 0", bus.if_req_o, bus.if_addr_o, bus.fetch_valid_o, RST_PC); else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_random;
        bit          m_busy, m_pend, m_fv, ev_take;
        int          m_rank, rank;
        logic [31:0] m_pc, m_tgt, m_fpc, tgt;
        do_reset();
        m_busy = 0; m_pend = 0; m_rank = 0; m_tgt = '0; m_fv = 0; m_pc = RST_PC; m_fpc = RST_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall   = ($urandom_range(0, 3) == 0);
            exc     = ($urandom_range(0, 19) == 0);
            eret    = ($urandom_range(0, 11) == 0);
            redir_v = ($urandom_range(0, 7) == 0);
            redir_t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            epc     = $urandom;
            bus.if_ack_i = m_busy && ($urandom_range(0, 1) == 1);

            rank = 0; tgt = '0;
            if (exc)          begin rank = 3; tgt = EXC_PC;  end
            else if (eret)    begin rank = 2; tgt = epc;     end
            else if (redir_v) begin rank = 1; tgt = redir_t; end
            ev_take = (rank > 0) && (!m_pend || rank >= m_rank);

            m_fv = 0;
            if (!m_busy) begin
                if (rank > 0) m_pc = tgt;
                m_busy = !stall;
            end else if (!bus.if_ack_i) begin
                if (ev_take) begin m_pend = 1; m_rank = rank; m_tgt = tgt; end
            end else begin
                if (rank == 0 && !m_pend) begin
                    m_fv = 1; m_fpc = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    m_pc = ev_take ? tgt : m_tgt;
                end
                m_pend = 0;
                m_busy = !stall;
            end

            tick();
            n_checks++; if (bus.if_req_o !== m_busy) $display("FAIL rnd_req c%0d got %b want %b", cyc, bus.if_req_o, m_busy); else n_pass++;
            n_checks++; if (bus.if_addr_o !== m_pc) $display("FAIL rnd_addr c%0d got %h want %h", cyc, bus.if_addr_o, m_pc); else n_pass++;
            n_checks++; if (bus.fetch_valid_o !== m_fv) $display("FAIL rnd_fv c%0d got %b want %b", cyc, bus.fetch_valid_o, m_fv); else n_pass++;
            n_checks++; if (bus.fetch_pc_o !== m_fpc) $display("FAIL rnd_fpc c%0d got %h want %h", cyc, bus.fetch_pc_o, m_fpc); else n_pass++;
            n_checks++; if (bus.fetch_pc_4_o !== m_fpc + 32'd4) $display("FAIL rnd_fpc4 c%0d got %h want %h", cyc, bus.fetch_pc_4_o, m_fpc + 32'd4); else n_pass++;
        end
        quiet();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 0;
        quiet();
        test_reset();
        test_free_run();
        test_delayed_ack();
        test_redirect_squash();
        test_priority();
        test_stall();
        test_wrap_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch-request generator for the 5-stage MIPS core, successor to the single-register PC. It owns the fetch address, issues requests to instruction memory over a req/ack handshake and supports variable memory latency. It applies pipeline stall, branch/jump redirect, exception entry and ERET with fixed priority. It squashes a fetch that a redirect has made stale.

## Interface
- XLEN, 32, address width
- RESET_PC, 32'hBFC0_0000, PC loaded on reset
- EXC_VEC, 32'hBFC0_0380, exception entry address
- INC, 4, sequential increment in bytes
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  pipeline hold; blocks issue of a new request
- redir_valid_i  in  1  branch/jump taken, single-cycle pulse from EX
- redir_target_i  in  XLEN  branch/jump target
- exc_req_i  in  1  exception entry pulse
- eret_req_i  in  1  return-from-exception pulse
- epc_i  in  XLEN  return address for ERET
- if_req_o  out  1  fetch request to instruction memory
- if_addr_o  out  XLEN  fetch address; equals current PC
- if_ack_i  in  1  memory has returned data for the outstanding request
- fetch_valid_o  out  1  delivered instruction is valid for IF/ID
- fetch_pc_o  out  XLEN  address of the delivered instruction
- fetch_pc_4_o  out  XLEN  fetch_pc_o + INC

## Operation
- Registers:
  - pc_q
  - state (IDLE, REQ)
  - pend_valid, pend_target
  - fetch_pc_q, fetch_valid_q
- Redirect target selection, priority high to low:
  - exc_req_i gives EXC_VEC.
  - eret_req_i gives epc_i.
  - redir_valid_i gives redir_target_i.
  - Simultaneous events: the highest priority wins; the others are dropped.
- IDLE:
  - if_req_o=0.
  - An event loads the target into pc_q directly.
  - If stall_i=0, go to REQ.
- REQ:
  - if_req_o=1, if_addr_o=pc_q.
  - if_addr_o stays stable until ack. An event arriving before ack is stored into pend, overwriting any lower- or equal-priority pending entry.
- Ack in REQ:
  - If neither pend_valid nor a same-cycle event is present: fetch_valid_q<=1, fetch_pc_q<=pc_q, pc_q<=pc_q+INC.
  - Otherwise the fetch is squashed: fetch_valid_q<=0, pc_q<=winning target (same-cycle event vs pending, by priority), pend cleared.
  - After ack: stay in REQ if stall_i=0, else go to IDLE.
- The IF/ID consumer accepts every fetch_valid_o pulse. stall_i never withdraws an outstanding request.
- Arithmetic: pc+INC is modulo 2^XLEN and wraps silently (all-ones-minus-3 + 4 = 0). Targets are taken unmodified; no alignment check.
- fetch_pc_4_o = fetch_pc_q + INC, computed combinationally.
- Reset values:
  - pc_q=RESET_PC, state=IDLE, pend_valid=0
  - fetch_valid_o=0, fetch_pc_o=RESET_PC
  - if_req_o=0
- Reset asserted mid-request abandons the request; memory must tolerate req dropping during reset.

## Timing
- First request: cycle 1 after rst_n release with stall_i=0 (state IDLE→REQ). if_req_o is high from cycle 2 onward.
- Zero-wait memory (ack in the same cycle as req): one fetch per cycle.
- fetch_valid_o rises the cycle after ack and is a one-cycle pulse per ack.
- Redirect latency:
  - Target appears on if_addr_o the cycle after the event when in IDLE.
  - Otherwise, the cycle after the outstanding ack.
- Exactly one squashed fetch per redirect while a request is outstanding; none when in IDLE.
- stall_i is sampled only for the IDLE/REQ transition; events are never blocked by stall_i.

## Test plan
- Reset then free-run, ack every cycle: if_addr_o = BFC00000, BFC00004, BFC00008; fetch_valid_o high from cycle 3 with matching fetch_pc_o and fetch_pc_4_o.
- Ack delayed 3 cycles: if_addr_o holds BFC00000 for 4 cycles; exactly one fetch_valid_o pulse.
- redir_valid_i to 00400100 two cycles before a delayed ack: the ack produces fetch_valid_o=0; next if_addr_o=00400100.
- exc_req_i, eret_req_i (epc 00400020) and redir_valid_i in the same cycle: next address BFC00380. A separate ERET-only event gives 00400020.
- stall_i held high across an ack: if_req_o drops after the ack. A redirect to 00400200 during the stall appears on if_addr_o when stall_i falls, with no squash.
- pc_q=FFFFFFFC, acked: next if_addr_o=00000000. Asserting rst_n mid-request restores if_req_o=0 and pc=BFC00000 asynchronously.
